// File: rtl/gray_input_debouncer_pkg.sv
// Shared types and helpers for the Gray-code switch debouncer.
// State encoding, Gray-to-binary conversion and popcount.
package gray_in_pkg;

   localparam int GRAY_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      COMMIT
   } db_state_t;

   function automatic logic [GRAY_W-1:0] gray2bin(
      input logic [GRAY_W-1:0] g
   );
      logic [GRAY_W-1:0] b;
      b[GRAY_W-1] = g[GRAY_W-1];
      for (int i = GRAY_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic int unsigned popcount(
      input logic [GRAY_W-1:0] v
   );
      int unsigned n;
      n = 0;
      for (int i = 0; i < GRAY_W; i++) begin
         n += {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/gray_input_debouncer_if.sv
// Switch-input / committed-value bundle of the debouncer.
// master drives gray_in, slave returns the debounced binary.
interface gray_input_debouncer_if
   import gray_in_pkg::*;
#(
   parameter int W = GRAY_W
);

   logic [W-1:0] gray_in;
   logic [W-1:0] bin_out;
   logic         bin_valid;
   logic         gray_err;

   modport master (
      output gray_in,
      input  bin_out,
      input  bin_valid,
      input  gray_err
   );

   modport slave (
      input  gray_in,
      output bin_out,
      output bin_valid,
      output gray_err
   );

endinterface

// File: rtl/gray_input_debouncer_sync.sv
// Two-flop synchroniser bringing raw switch bits into clk.
// Each bit is synchronised independently; q is the 2nd stage.
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_d, meta_q;
   logic [W-1:0] sync_d, sync_q;

   // next values of the two stages
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // synchroniser chain, cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gray_input_debouncer.sv
// Debounces a Gray-coded switch bank and commits it as binary.
// Optional GRAY_ERR_CHECK_EN flags multi-bit Gray transitions.
module gray_input_debouncer
   import gray_in_pkg::*;
#(
   parameter int W           = GRAY_W,
   parameter int CLK_HZ      = 100_000_000,
   parameter int DEBOUNCE_MS = 10
) (
   input logic                   clk,
   input logic                   rst_n,
   gray_input_debouncer_if.slave bus
);

   localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int CW        = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [W-1:0]  s;
   db_state_t     state_d, state_q;
   logic [W-1:0]  stable_d, stable_q;
   logic [W-1:0]  cand_d, cand_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic [W-1:0]  bin_d, bin_q;
   logic          valid_d, valid_q;

   sync_2ff #(
      .W (W)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.gray_in),
      .q     (s)
   );

   // debounce FSM: track a candidate until it has been stable long enough
   always_comb begin
      state_d  = state_q;
      stable_d = stable_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      valid_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s != stable_q) begin
               cand_d  = s;
               cnt_d   = '0;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (s == stable_q) begin
               state_d = IDLE;
            end else if (s != cand_q) begin
               cand_d = s;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = COMMIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         COMMIT: begin
            stable_d = cand_q;
            bin_d    = gray2bin(cand_q);
            valid_d  = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and output registers; reset discards any pending candidate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         stable_q <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         bin_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         stable_q <= stable_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         valid_q  <= valid_d;
      end
   end

`ifdef GRAY_ERR_CHECK_EN
   logic err_d, err_q;

   // sample the transition legality at commit, hold until the next one
   always_comb begin
      err_d = err_q;
      if (state_q == COMMIT) begin
         err_d = popcount(cand_q ^ stable_q) > 1;
      end
   end

   // error flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.gray_err = err_q;
`else
   assign bus.gray_err = 1'b0;
`endif

   assign bus.bin_out   = bin_q;
   assign bus.bin_valid = valid_q;

endmodule
